// File: rtl/store_data_queue.sv
// In-order store data queue: allocates at dispatch, captures AGU results,
// marks stores committed in program order and drains committed stores to the D-cache.
module store_data_queue #(
    parameter  int SDQ_ENTRIES = 8,
    localparam int PW          = $clog2(SDQ_ENTRIES)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          disp_vld_i,
    output logic          sdq_full_o,
    output logic [PW-1:0] sdq_disp_idx_o,
    output logic [PW:0]   sdq_tail_o,
    output logic [PW:0]   sdq_head_o,
    output logic          sdq_empty_o,
    input  logic          exec_vld_i,
    input  logic [PW-1:0] exec_sdq_idx_i,
    input  logic [31:0]   exec_addr_i,
    input  logic [31:0]   exec_data_i,
    input  logic [3:0]    exec_be_i,
    input  logic          commit_vld_i,
    output logic          mem_req_vld_o,
    output logic [31:0]   mem_req_addr_o,
    output logic [31:0]   mem_req_data_o,
    output logic [3:0]    mem_req_be_o,
    input  logic          mem_req_rdy_i
);

    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [SDQ_ENTRIES-1:0]       valid_q, valid_d;
    logic [SDQ_ENTRIES-1:0]       addr_valid_q, addr_valid_d;
    logic [SDQ_ENTRIES-1:0]       committed_q, committed_d;
    logic [SDQ_ENTRIES-1:0][31:0] addr_q, addr_d;
    logic [SDQ_ENTRIES-1:0][31:0] data_q, data_d;
    logic [SDQ_ENTRIES-1:0][3:0]  be_q, be_d;
    logic [PW:0]                  head_q, head_d;
    logic [PW:0]                  cmt_q, cmt_d;
    logic [PW:0]                  tail_q, tail_d;

    logic [PW-1:0] head_idx, cmt_idx, tail_idx;
    logic          full, empty, req_vld;

    assign head_idx = head_q[PW-1:0];
    assign cmt_idx  = cmt_q[PW-1:0];
    assign tail_idx = tail_q[PW-1:0];

    assign full    = (tail_idx == head_idx) && (tail_q[PW] != head_q[PW]);
    assign empty   = (tail_q == head_q);
    assign req_vld = valid_q[head_idx] & addr_valid_q[head_idx] & committed_q[head_idx];

    always_comb begin
        valid_d      = valid_q;
        addr_valid_d = addr_valid_q;
        committed_d  = committed_q;
        addr_d       = addr_q;
        data_d       = data_q;
        be_d         = be_q;
        head_d       = head_q;
        cmt_d        = cmt_q;
        tail_d       = tail_q;

        if (disp_vld_i && !full) begin
            valid_d[tail_idx]      = 1'b1;
            addr_valid_d[tail_idx] = 1'b0;
            committed_d[tail_idx]  = 1'b0;
            addr_d[tail_idx]       = '0;
            data_d[tail_idx]       = '0;
            be_d[tail_idx]         = '0;
            tail_d                 = tail_q + PTR_ONE;
        end

        // Fields are written even for a stale index; keeping that case out is the issuer's job.
        if (exec_vld_i) begin
            addr_d[exec_sdq_idx_i]       = exec_addr_i;
            data_d[exec_sdq_idx_i]       = exec_data_i;
            be_d[exec_sdq_idx_i]         = exec_be_i;
            addr_valid_d[exec_sdq_idx_i] = 1'b1;
        end

        if (commit_vld_i && (cmt_q != tail_q)) begin
            committed_d[cmt_idx] = 1'b1;
            cmt_d                = cmt_q + PTR_ONE;
        end

        if (req_vld && mem_req_rdy_i) begin
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q      <= '0;
            addr_valid_q <= '0;
            committed_q  <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            be_q         <= '0;
            head_q       <= '0;
            cmt_q        <= '0;
            tail_q       <= '0;
        end else begin
            valid_q      <= valid_d;
            addr_valid_q <= addr_valid_d;
            committed_q  <= committed_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            be_q         <= be_d;
            head_q       <= head_d;
            cmt_q        <= cmt_d;
            tail_q       <= tail_d;
        end
    end

    assign sdq_full_o     = full;
    assign sdq_empty_o    = empty;
    assign sdq_disp_idx_o = tail_idx;
    assign sdq_tail_o     = tail_q;
    assign sdq_head_o     = head_q;
    assign mem_req_vld_o  = req_vld;
    assign mem_req_addr_o = req_vld ? addr_q[head_idx] : '0;
    assign mem_req_data_o = req_vld ? data_q[head_idx] : '0;
    assign mem_req_be_o   = req_vld ? be_q[head_idx]   : '0;

endmodule
